// File: rtl/gi_imix_ctl_pkg.sv
// Shared AES decrypt-datapath definitions: widths and the column-mix
// sequencer state encoding.
package gi_aes_defs;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } imix_state_t;

endpackage

// File: rtl/gi_mixd.sv
// Combinational AES InvMixColumns on one 32-bit column; byte 0 of the
// column is [31:24]. All GF(2^8) arithmetic lives here.
module gi_mixd
  import gi_aes_defs::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Circulant matrix rows {0e,0b,0d,09} rotated right per output byte.
  assign col_out = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                    mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                    muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                    mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};

endmodule

// File: rtl/gi_imix_ctl.sv
// InvMixColumns sequencer: time-shares NMIX gi_mixd column mixers over the
// four state columns, with a same-cycle bypass for the final decrypt round.
module gi_imix_ctl
  import gi_aes_defs::*;
#(
  parameter int NMIX = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_bypass,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  if (!(NMIX == 1 || NMIX == 2 || NMIX == 4)) begin : g_bad_nmix
    $error("gi_imix_ctl: NMIX must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(NMIX);
  localparam logic [1:0] LAST_COL = 2'(4 - NMIX);

  imix_state_t            state, state_nxt;
  logic [AES_STATE_W-1:0] blk, blk_nxt, mixed;
  logic [1:0]             col, col_nxt;
  logic [AES_COL_W-1:0]   mix_in  [NMIX];
  logic [AES_COL_W-1:0]   mix_out [NMIX];
  logic                   accept;

  // Column c occupies bits [127-32c -: 32]; return its 32-bit LSB slot.
  function automatic logic [1:0] slot_of(input logic [1:0] c, input int i);
    return 2'd3 - (c + 2'(i));
  endfunction

  always_comb begin
    for (int i = 0; i < NMIX; i++) begin
      mix_in[i] = blk[32*slot_of(col, i) +: 32];
    end
  end

  for (genvar g = 0; g < NMIX; g++) begin : g_mix
    gi_mixd u_mixd (
      .col_in (mix_in[g]),
      .col_out(mix_out[g])
    );
  end

  // In-place write-back of the columns mixed this cycle.
  always_comb begin
    mixed = blk;
    for (int i = 0; i < NMIX; i++) begin
      mixed[32*slot_of(col, i) +: 32] = mix_out[i];
    end
  end

  assign in_rdy = (state == IDLE) | ((state == DONE) & out_rdy);
  assign accept = in_vld & in_rdy;

  always_comb begin
    state_nxt = state;
    blk_nxt   = blk;
    col_nxt   = col;
    unique case (state)
      IDLE: begin
        if (accept) begin
          blk_nxt   = in_data;
          col_nxt   = '0;
          state_nxt = in_bypass ? DONE : MIX;
        end
      end
      MIX: begin
        blk_nxt = mixed;
        col_nxt = col + COL_STEP;
        if (col == LAST_COL) state_nxt = DONE;
      end
      DONE: begin
        // Result leaves and the next block may enter on the same edge.
        if (out_rdy) begin
          if (accept) begin
            blk_nxt   = in_data;
            col_nxt   = '0;
            state_nxt = in_bypass ? DONE : MIX;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        col_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      blk   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      blk   <= blk_nxt;
      col   <= col_nxt;
    end
  end

  assign out_vld  = (state == DONE);
  assign out_data = blk;
  assign busy     = (state == MIX) | (state == DONE);

endmodule

// File: tb/tb_gi_imix_ctl.sv
// Scoreboard bench for gi_imix_ctl: directed FIPS-197 column vectors, bypass,
// backpressure, back-to-back, mid-operation reset and a random soak.
module tb_gi_imix_ctl;

  localparam logic [127:0] VA  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] EA  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VD  = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
  localparam logic [127:0] ED  = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
  localparam logic [127:0] VB  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [31:0]  MIXK = 32'h02030101;
  localparam logic [31:0]  INVK = 32'h0e0b0d09;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_vld, in_rdy, in_bypass, out_vld, out_rdy, busy;
  logic [127:0] in_data, out_data;
  logic         in_vld2, in_rdy2, out_vld2, busy2;
  logic         in_vld4, in_rdy4, out_vld4, busy4;
  logic [127:0] in_data_n, out_data2, out_data4;

  gi_imix_ctl #(.NMIX(1)) dut (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_bypass(in_bypass), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .busy(busy));
  gi_imix_ctl #(.NMIX(2)) dut2 (
    .clk(clk), .reset(reset), .in_vld(in_vld2), .in_rdy(in_rdy2), .in_data(in_data_n),
    .in_bypass(1'b0), .out_vld(out_vld2), .out_rdy(1'b1), .out_data(out_data2), .busy(busy2));
  gi_imix_ctl #(.NMIX(4)) dut4 (
    .clk(clk), .reset(reset), .in_vld(in_vld4), .in_rdy(in_rdy4), .in_data(in_data_n),
    .in_bypass(1'b0), .out_vld(out_vld4), .out_rdy(1'b1), .out_data(out_data4), .busy(busy4));

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    logic         byp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant column transform: out[r] = sum_j k[(j-r) mod 4] * in[j].
  function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] kk);
    logic [127:0] r;
    logic [7:0] acc, aj, kj;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          aj = s[127-32*c-8*j -: 8];
          kj = kk[31-8*((j-row+4)%4) -: 8];
          acc ^= gmul(aj, kj);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic b, input logic [127:0] e,
                      output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    in_data = d; in_bypass = b; in_vld = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1;
        q.push_back('{din: d, exp: e, byp: b});
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    in_bypass = $urandom_range(0, 1);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_rdy never rose, required 1");
    end
  endtask

  task automatic latency(input string nm, input int lat_req);
    int n;
    n = 1;
    while (!out_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 128'(n), 128'(lat_req));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 128'(q.size()), 128'd0);
  endtask

  // Monitor: pops on every accepted output and checks stall stability.
  initial begin
    item_t it;
    bit prev_stall;
    logic [127:0] prev_data;
    prev_stall = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_stall) begin
          chk("hold_out_vld", 128'(out_vld), 128'd1);
          chk("hold_out_data", out_data, prev_data);
        end
        if (out_vld && q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_out_vld: out_vld=1 data %h, required no output", out_data);
        end else if (out_vld && out_rdy) begin
          it = q.pop_front();
          chk("out_data", out_data, it.exp);
          if (!it.byp) chk("mixcolumns_roundtrip", circ(out_data, MIXK), it.din);
        end
      end
      prev_stall = !reset && out_vld && !out_rdy;
      prev_data  = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, t2, rel, lat2, lat4;
    int ts[4];
    logic [127:0] d, e;
    logic b;
    reset = 1'b1; in_vld = 1'b0; in_bypass = 1'b0; in_data = '0; out_rdy = 1'b1;
    in_vld2 = 1'b0; in_vld4 = 1'b0; in_data_n = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_in_rdy", 128'(in_rdy), 128'd1);
    chk("reset_out_vld", 128'(out_vld), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_out_data", out_data, 128'd0);
    chk("reset_nmix2_in_rdy", 128'({in_rdy2, busy2}), 128'd2);
    chk("reset_nmix4_in_rdy", 128'({in_rdy4, busy4}), 128'd2);

    // FIPS-197 columns, NMIX=1.
    send(VA, 1'b0, EA, ta);
    latency("latency_mix_nmix1", 5);
    drain();

    // Same vector on NMIX=2 and NMIX=4 instances.
    in_data_n = VA; in_vld2 = 1'b1; in_vld4 = 1'b1;
    @(posedge clk); #1;
    in_vld2 = 1'b0; in_vld4 = 1'b0; in_data_n = '1;
    lat2 = 0; lat4 = 0;
    for (int k = 1; k <= 10; k++) begin
      if (out_vld2 && lat2 == 0) begin lat2 = k; chk("nmix2_out_data", out_data2, EA); end
      if (out_vld4 && lat4 == 0) begin lat4 = k; chk("nmix4_out_data", out_data4, EA); end
      @(posedge clk); #1;
    end
    chk("latency_mix_nmix2", 128'(lat2), 128'd3);
    chk("latency_mix_nmix4", 128'(lat4), 128'd2);

    // Bypass single and back-to-back stream.
    send(VB, 1'b1, VB, ta);
    latency("latency_bypass", 1);
    drain();
    for (int i = 0; i < 4; i++) begin
      d = {VB[95:0], 8'(i), VB[127:104]};
      send(d, 1'b1, d, ts[i]);
    end
    for (int i = 1; i < 4; i++) chk("bypass_stream_spacing", 128'(ts[i] - ts[i-1]), 128'd1);
    drain();

    // Backpressure: hold result for 7 cycles, next block enters on release.
    out_rdy = 1'b0;
    send(VA, 1'b0, EA, ta);
    rel = -1;
    fork
      send(VD, 1'b0, ED, t2);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_vld && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 7; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_out_vld", 128'(out_vld), 128'd1);
          chk("bp_out_data", out_data, EA);
          chk("bp_in_rdy_low", 128'(in_rdy), 128'd0);
        end
        @(posedge clk); #1 out_rdy = 1'b1;
        @(negedge clk);
        rel = cyc;
        chk("bp_release_in_rdy", 128'(in_rdy), 128'd1);
      end
    join
    chk("bp_same_cycle_accept", 128'(t2), 128'(rel));
    drain();

    // Back-to-back mix, no idle cycle between DONE and next MIX.
    send(VA, 1'b0, EA, ta);
    send(VD, 1'b0, ED, tb);
    chk("b2b_mix_spacing", 128'(tb - ta), 128'd5);
    drain();

    // Reset in the second MIX cycle drops the transaction.
    send(VA, 1'b0, EA, ta);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q.delete();
    chk("rst_mid_in_rdy", 128'(in_rdy), 128'd1);
    chk("rst_mid_out_vld", 128'(out_vld), 128'd0);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    repeat (8) @(posedge clk);
    #1;
    send(VD, 1'b0, ED, ta);
    drain();

    // Random soak against the reference model.
    rnd_en = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = {$urandom, $urandom, $urandom, $urandom};
      b = ($urandom_range(0, 3) == 0);
      e = b ? d : circ(d, INVK);
      send(d, b, e, ta);
    end
    rnd_en = 0;
    @(posedge clk); #2 out_rdy = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
